// File: rtl/resp_capture_misr.sv
// Response capture block: folds each accepted response vector into a MISR signature.
// Optional vector comparison against exp_vec is enabled by defining RESP_CMP_EN.
module resp_capture_misr #(
  parameter int                  VEC_WIDTH  = 246,
  parameter int                  VEC_LENGTH = 4,
  parameter int                  SIG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0] MISR_POLY = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] MISR_SEED = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 resp_valid,
  input  logic [VEC_WIDTH-1:0] resp_vec,
  input  logic [VEC_WIDTH-1:0] exp_vec,
  output logic                 resp_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [15:0]          mismatch_cnt,
  output logic [15:0]          first_fail_idx,
  output logic [1:0]           state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam int NCHUNK    = (VEC_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PAD_WIDTH = NCHUNK * SIG_WIDTH;
  localparam logic [15:0] LAST_IDX = 16'(VEC_LENGTH - 1);

  // Handshake: a response is accepted on any rising edge where resp_valid and
  // resp_ready are both high; resp_ready depends only on state, never on resp_valid.
  logic accept;
  logic restart;
  logic last_accept;
  logic [PAD_WIDTH-1:0] padded;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;

  assign resp_ready  = (state == CAPTURE);
  assign busy        = (state == CAPTURE);
  assign done        = (state == DONE);
  assign accept      = resp_valid && resp_ready;
  assign restart     = start && (state != CAPTURE);
  assign last_accept = accept && (vec_count == LAST_IDX);

  always_comb begin
    padded = '0;
    padded[VEC_WIDTH-1:0] = resp_vec;
    fold = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      fold = fold ^ padded[c*SIG_WIDTH +: SIG_WIDTH];
    end
    misr_next = {signature[SIG_WIDTH-2:0], 1'b0}
              ^ (signature[SIG_WIDTH-1] ? MISR_POLY : '0)
              ^ fold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec_count <= '0;
      signature <= MISR_SEED;
    end else begin
      case (state)
        CAPTURE: begin
          if (accept) begin
            signature <= misr_next;
            vec_count <= vec_count + 16'd1;
            if (last_accept) state <= DONE;
          end
        end
        IDLE, DONE: begin
          if (restart) begin
            state     <= CAPTURE;
            vec_count <= '0;
            signature <= MISR_SEED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RESP_CMP_EN
  logic vec_differs;
  assign vec_differs = (resp_vec != exp_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_cnt   <= '0;
      first_fail_idx <= 16'hFFFF;
    end else if (restart) begin
      mismatch_cnt   <= '0;
      first_fail_idx <= 16'hFFFF;
    end else if (accept && vec_differs) begin
      if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
      // The count only returns to zero on restart, so zero marks the first miss of a run.
      if (mismatch_cnt == 16'h0000) first_fail_idx <= vec_count;
    end
  end
`else
  logic exp_vec_unused;
  assign exp_vec_unused = ^exp_vec;
  assign mismatch_cnt   = 16'h0000;
  assign first_fail_idx = 16'hFFFF;
`endif

endmodule

// File: tb/tb_resp_capture_misr.sv
// Directed bench for resp_capture_misr: reset, single-step MISR, gapped run,
// ignored events, optional comparison (RESP_CMP_EN) and restart.
module tb_resp_capture_misr;

  localparam int VW = 246;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          resp_valid;
  logic [VW-1:0] resp_vec;
  logic [VW-1:0] exp_vec;
  logic          resp_ready;
  logic          busy;
  logic          done;
  logic [15:0]   vec_count;
  logic [31:0]   signature;
  logic [15:0]   mismatch_cnt;
  logic [15:0]   first_fail_idx;
  logic [1:0]    state;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  resp_capture_misr dut (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
    .resp_vec(resp_vec), .exp_vec(exp_vec), .resp_ready(resp_ready),
    .busy(busy), .done(done), .vec_count(vec_count), .signature(signature),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Bit-serial fold: bit i of the vector lands on signature bit i mod 32.
  function automatic logic [31:0] model_next(input logic [31:0] s, input logic [VW-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < VW; i++) f[i % 32] = f[i % 32] ^ v[i];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [VW-1:0] make_vec(input logic [31:0] s);
    logic [VW-1:0] r;
    for (int i = 0; i < VW; i++) r[i] = s[i % 32] ^ (((i / 32) % 2) == 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vec(input int gap, input logic [VW-1:0] v, input logic [VW-1:0] ev);
    int n;
    repeat (gap) tick();
    resp_valid = 1'b1;
    resp_vec   = v;
    exp_vec    = ev;
    n = 0;
    while (!resp_ready && n < 20) begin
      tick();
      n++;
    end
    if (!resp_ready) check("ready_timeout", 32'(resp_ready), 32'd1);
    tick();
    resp_valid = 1'b0;
  endtask

  logic [VW-1:0] vecs [4];
  logic [VW-1:0] exps [4];
  int gaps [4];
  logic [31:0] model_sig;
  logic [31:0] run_sig;

  initial begin
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp_vec = '0; exp_vec = '0;
    vecs[0] = make_vec(32'h12345678);
    vecs[1] = make_vec(32'hDEADBEEF);
    vecs[2] = make_vec(32'h0F0F00FF);
    vecs[3] = make_vec(32'h80000001);
    for (int k = 0; k < 4; k++) exps[k] = vecs[k];
    exps[1][5]   = ~exps[1][5];
    exps[3][240] = ~exps[3][240];
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_ready", 32'(resp_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vc", 32'(vec_count), 32'd0);
    check("rst_sig", signature, 32'hFFFFFFFF);
    check("rst_mm", 32'(mismatch_cnt), 32'd0);
    check("rst_ffi", 32'(first_fail_idx), 32'h0000FFFF);

    // resp_valid ignored in IDLE
    resp_valid = 1'b1; resp_vec = vecs[0];
    repeat (2) tick();
    resp_valid = 1'b0;
    check("idle_vc", 32'(vec_count), 32'd0);
    check("idle_sig", signature, 32'hFFFFFFFF);

    // Single step with all-zero vectors, then mid-run reset
    pulse_start();
    check("start_state", 32'(state), 32'(S_CAPTURE));
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(resp_ready), 32'd1);
    send_vec(0, '0, '0);
    check("step1_sig", signature, 32'hFB3EE249);
    check("step1_vc", 32'(vec_count), 32'd1);
    send_vec(0, '0, '0);
    check("step2_sig", signature, 32'hF2BCD925);
    check("step2_vc", 32'(vec_count), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_state", 32'(state), 32'(S_IDLE));
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_vc", 32'(vec_count), 32'd0);
    check("midrst_sig", signature, 32'hFFFFFFFF);
    check("midrst_ready", 32'(resp_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Gapped run of 4 vectors with an ignored start in the middle
    model_sig = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      model_sig = model_next(model_sig, vecs[k]);
      exp_q.push_back(model_sig);
    end
    run_sig = model_sig;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      if (k == 3) check("pre_last_done", 32'(done), 32'd0);
      send_vec(gaps[k], vecs[k], exps[k]);
      e = exp_q.pop_front();
      check($sformatf("run_sig%0d", k), signature, e);
      check($sformatf("run_vc%0d", k), 32'(vec_count), 32'(k + 1));
      if (k == 1) begin
        pulse_start();
        check("ign_start_state", 32'(state), 32'(S_CAPTURE));
        check("ign_start_vc", 32'(vec_count), 32'd2);
        check("ign_start_sig", signature, e);
      end
    end
    check("done_flag", 32'(done), 32'd1);
    check("done_state", 32'(state), 32'(S_DONE));
    check("done_ready", 32'(resp_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd0);

    // resp_valid held high in DONE
    resp_valid = 1'b1; resp_vec = vecs[2]; exp_vec = '0;
    repeat (3) tick();
    resp_valid = 1'b0;
    check("hold_vc", 32'(vec_count), 32'd4);
    check("hold_sig", signature, run_sig);
    check("hold_done", 32'(done), 32'd1);

`ifdef RESP_CMP_EN
    check("cmp_mm", 32'(mismatch_cnt), 32'd2);
    check("cmp_ffi", 32'(first_fail_idx), 32'd1);
`else
    check("nocmp_mm", 32'(mismatch_cnt), 32'd0);
    check("nocmp_ffi", 32'(first_fail_idx), 32'h0000FFFF);
`endif

    // Restart from DONE and repeat the same run without gaps
    pulse_start();
    check("re_state", 32'(state), 32'(S_CAPTURE));
    check("re_sig", signature, 32'hFFFFFFFF);
    check("re_vc", 32'(vec_count), 32'd0);
    check("re_mm", 32'(mismatch_cnt), 32'd0);
    check("re_ffi", 32'(first_fail_idx), 32'h0000FFFF);
    for (int k = 0; k < 4; k++) send_vec(0, vecs[k], vecs[k]);
    check("re_final_sig", signature, run_sig);
    check("re_done", 32'(done), 32'd1);
    check("re_clean_mm", 32'(mismatch_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
